multicycle_ctrl_fsm: RTL and testbench

- Main control FSM for the multi-cycle RV32I core variant; sequences the shared PC/IR/ALU/register-file/unified-memory datapath through fetch, decode, execute, memory and writeback.
- Takes opcode/funct3 from the IR plus the ALU zero flag and a memory ready handshake.
- Drives all datapath enables and mux selects, and flags retired instructions and memory wait timeouts.

---
 rtl/multicycle_ctrl_fsm.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Optional macro ILLEGAL_TRAP_EN sends unknown opcodes to a sticky TRAP state instead of a NOP.
module multicycle_ctrl_fsm #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic [3:0] state,
    output logic       instr_retired,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t            st;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_wait;
    logic              at_limit;

    // Only states that stall on the memory handshake can time out.
    assign in_wait  = (st == S_FETCH) || (st == S_MEMREAD) || (st == S_MEMWRITE);
    assign at_limit = in_wait && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT));
    assign state    = st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            if (in_wait && !mem_ready && !at_limit) wait_cnt <= wait_cnt + WAIT_W'(1);
            else                                    wait_cnt <= '0;

            case (st)
                S_FETCH:    if (mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: st <= S_MEMADR;
                        OP_RTYPE:          st <= S_EXECR;
                        OP_ITYPE:          st <= S_EXECI;
                        OP_JAL:            st <= S_JAL;
                        OP_BRANCH:         st <= S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                        default:           st <= S_TRAP;
`else
                        default:           st <= S_FETCH;
`endif
                    endcase
                end
                S_MEMADR:   st <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: begin
                    if (mem_ready)     st <= S_MEMWB;
                    else if (at_limit) st <= S_FETCH;
                end
                S_MEMWB:    st <= S_FETCH;
                S_MEMWRITE: if (mem_ready || at_limit) st <= S_FETCH;
                S_EXECR:    st <= S_ALUWB;
                S_EXECI:    st <= S_ALUWB;
                S_ALUWB:    st <= S_FETCH;
                S_JAL:      st <= S_ALUWB;
                S_BRANCH:   st <= S_FETCH;
                S_TRAP:     st <= S_TRAP;
                default:    st <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_retired = 1'b0;
        mem_timeout   = 1'b0;
        if (rst) begin
            mem_timeout = at_limit;
            case (st)
                S_FETCH: begin
                    mem_read   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: begin
                    adr_src  = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    result_src    = 2'b01;
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src       = 1'b1;
                    mem_write     = 1'b1;
                    instr_retired = mem_ready;
                end
                S_EXECR: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
                S_EXECI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 2'b10;
                    alu_op        = 2'b01;
                    instr_retired = 1'b1;
                    // beq / bne only; other branch flavours never redirect
                    if (funct3 == 3'b000)      pc_write = zero;
                    else if (funct3 == 3'b001) pc_write = ~zero;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed vector table, hand sequences for
// timeout and async reset, and random instruction streams against a per-instruction trace model.
module tb_multicycle_ctrl_fsm;

    localparam int MAX_WAIT = 15;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [3:0] state;
    logic       instr_retired, mem_timeout;
    logic [21:0] dut_vec;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl_fsm #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
        .state(state), .instr_retired(instr_retired), .mem_timeout(mem_timeout)
    );

    assign dut_vec = {state, imm_src, pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
                      result_src, alu_src_a, alu_src_b, alu_op, instr_retired, mem_timeout};

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks required completion", n_checks);
        $fatal(1, "watchdog");
    end

    // reference model: outputs per state straight from the state descriptions
    function automatic logic [1:0] ref_imm(input logic [6:0] o);
        if (o == OP_STORE)       return 2'b01;
        else if (o == OP_BRANCH) return 2'b10;
        else if (o == OP_JAL)    return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [15:0] ref_out(input int st, input logic mr, input logic z,
                                             input logic [2:0] f3, input logic to);
        logic pcw = 0, adr = 0, mrd = 0, mwr = 0, irw = 0, rw = 0, ret = 0;
        logic [1:0] res = 0, a = 0, b = 0, alu = 0;
        case (st)
            0:  begin mrd = 1; b = 2; res = 2; irw = mr; pcw = mr; end
            1:  begin a = 1; b = 1; end
            2:  begin a = 2; b = 1; end
            3:  begin adr = 1; mrd = 1; end
            4:  begin res = 1; rw = 1; ret = 1; end
            5:  begin adr = 1; mwr = 1; ret = mr; end
            6:  begin a = 2; b = 0; alu = 2; end
            7:  begin a = 2; b = 1; alu = 2; end
            8:  begin res = 0; rw = 1; ret = 1; end
            9:  begin a = 1; b = 2; pcw = 1; end
            10: begin a = 2; alu = 1; ret = 1; pcw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? ~z : 1'b0; end
            default: ;
        endcase
        return {pcw, adr, mrd, mwr, irw, rw, res, a, b, alu, ret, to};
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // driver tasks: inputs change 1 after the rising edge, outputs sampled on the falling edge
    task automatic drive(input logic mr, input logic z, input logic [6:0] o, input logic [2:0] f3);
        mem_ready = mr; zero = z; op = o; funct3 = f3;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = OP_STORE; funct3 = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", dut_vec, {4'd0, 2'b01, 16'h0000});
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // scoreboard for the random phase
    logic [11:0] stim_q[$];
    logic [21:0] exp_q[$];
    logic [6:0]  g_op;
    logic [2:0]  g_f3;
    logic        g_z;

    task automatic emit(input int st, input logic mr, input logic to);
        stim_q.push_back({g_op, g_f3, g_z, mr});
        exp_q.push_back({4'(st), ref_imm(g_op), ref_out(st, mr, g_z, g_f3, to)});
    endtask

    function automatic int pick_lat();
        int r = $urandom_range(0, 19);
        if (r < 14) return $urandom_range(0, 3);
        if (r < 17) return MAX_WAIT;
        return MAX_WAIT + 1 + $urandom_range(0, 5);
    endfunction

    // a memory-handshake phase: either completes after lat idle cycles or times out
    task automatic gen_wait(input int st, output logic ok);
        int lat = pick_lat();
        if (lat > MAX_WAIT) begin
            for (int i = 0; i < MAX_WAIT; i++) emit(st, 1'b0, 1'b0);
            emit(st, 1'b0, 1'b1);
            ok = 1'b0;
        end else begin
            for (int i = 0; i < lat; i++) emit(st, 1'b0, 1'b0);
            emit(st, 1'b1, 1'b0);
            ok = 1'b1;
        end
    endtask

    task automatic gen_instr();
        logic ok;
        int   kind;
`ifdef ILLEGAL_TRAP_EN
        kind = $urandom_range(0, 5);
`else
        kind = $urandom_range(0, 6);
`endif
        case (kind)
            0: g_op = OP_LOAD;
            1: g_op = OP_STORE;
            2: g_op = OP_RTYPE;
            3: g_op = OP_ITYPE;
            4: g_op = OP_JAL;
            5: g_op = OP_BRANCH;
            default: g_op = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b0110111;
        endcase
        g_f3 = 3'($urandom_range(0, 7));
        g_z  = 1'($urandom_range(0, 1));
        do gen_wait(0, ok); while (!ok);
        emit(1, 1'($urandom_range(0, 1)), 1'b0);
        case (kind)
            0: begin
                emit(2, 1'($urandom_range(0, 1)), 1'b0);
                gen_wait(3, ok);
                if (ok) emit(4, 1'($urandom_range(0, 1)), 1'b0);
            end
            1: begin
                emit(2, 1'($urandom_range(0, 1)), 1'b0);
                gen_wait(5, ok);
            end
            2: begin emit(6, 1'($urandom_range(0, 1)), 1'b0); emit(8, 1'($urandom_range(0, 1)), 1'b0); end
            3: begin emit(7, 1'($urandom_range(0, 1)), 1'b0); emit(8, 1'($urandom_range(0, 1)), 1'b0); end
            4: begin emit(9, 1'($urandom_range(0, 1)), 1'b0); emit(8, 1'($urandom_range(0, 1)), 1'b0); end
            5: emit(10, 1'($urandom_range(0, 1)), 1'b0);
            default: ;
        endcase
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        z;
        int          len;
        logic [15:0] mr;
        logic [63:0] states;
        logic [15:0] pcw;
        logic [15:0] rw;
        logic [15:0] ret;
    } dvec_t;

    dvec_t tbl[11];

    initial begin
        logic [6:0] exp7;
        logic [6:0] act7;
        tbl[0]  = '{OP_RTYPE,  3'd0, 1'b0, 5, 16'h0001, 64'h08610,    16'h0001, 16'h0008, 16'h0008};
        tbl[1]  = '{OP_LOAD,   3'd2, 1'b0, 8, 16'h0021, 64'h04333210, 16'h0001, 16'h0040, 16'h0040};
        tbl[2]  = '{OP_BRANCH, 3'd0, 1'b1, 4, 16'h0001, 64'h0A10,     16'h0005, 16'h0000, 16'h0004};
        tbl[3]  = '{OP_BRANCH, 3'd0, 1'b0, 4, 16'h0001, 64'h0A10,     16'h0001, 16'h0000, 16'h0004};
        tbl[4]  = '{OP_BRANCH, 3'd1, 1'b0, 4, 16'h0001, 64'h0A10,     16'h0005, 16'h0000, 16'h0004};
        tbl[5]  = '{OP_BRANCH, 3'd1, 1'b1, 4, 16'h0001, 64'h0A10,     16'h0001, 16'h0000, 16'h0004};
        tbl[6]  = '{OP_BRANCH, 3'd4, 1'b1, 4, 16'h0001, 64'h0A10,     16'h0001, 16'h0000, 16'h0004};
        tbl[7]  = '{OP_JAL,    3'd0, 1'b0, 5, 16'h0001, 64'h08910,    16'h0005, 16'h0008, 16'h0008};
        tbl[8]  = '{OP_STORE,  3'd2, 1'b0, 5, 16'h0009, 64'h05210,    16'h0001, 16'h0000, 16'h0008};
        tbl[9]  = '{OP_ITYPE,  3'd0, 1'b0, 5, 16'h0001, 64'h08710,    16'h0001, 16'h0008, 16'h0008};
`ifdef ILLEGAL_TRAP_EN
        tbl[10] = '{7'b0000000, 3'd0, 1'b0, 4, 16'h0001, 64'hBB10,    16'h0001, 16'h0000, 16'h0000};
`else
        tbl[10] = '{7'b0000000, 3'd0, 1'b0, 3, 16'h0001, 64'h010,     16'h0001, 16'h0000, 16'h0000};
`endif

        do_reset();

        // table-driven vectors: state, pc_write, reg_write, instr_retired per cycle
        foreach (tbl[k]) begin
            for (int i = 0; i < tbl[k].len; i++) begin
                drive(tbl[k].mr[i], tbl[k].z, tbl[k].op, tbl[k].f3);
                exp7 = {tbl[k].states[4*i +: 4], tbl[k].pcw[i], tbl[k].rw[i], tbl[k].ret[i]};
                act7 = {state, pc_write, reg_write, instr_retired};
                check($sformatf("vec%0d_cyc%0d", k, i), {15'b0, act7}, {15'b0, exp7});
                advance();
            end
        end

        // sw with memory never ready: timeout on the 16th MEMWRITE cycle
        do_reset();
        drive(1'b1, 1'b0, OP_STORE, 3'd2); advance();
        drive(1'b0, 1'b0, OP_STORE, 3'd2);
        check("sw_decode_imm", {16'b0, state, imm_src}, {16'b0, 4'd1, 2'b01});
        advance();
        drive(1'b0, 1'b0, OP_STORE, 3'd2); advance();
        for (int i = 1; i <= MAX_WAIT + 1; i++) begin
            drive(1'b0, 1'b0, OP_STORE, 3'd2);
            check($sformatf("sw_wait%0d", i), {18'b0, state[2:0], mem_write, mem_timeout, instr_retired},
                  {18'b0, 3'd5, 1'b1, (i == MAX_WAIT + 1), 1'b0});
            advance();
        end
        drive(1'b0, 1'b0, OP_STORE, 3'd2);
        check("sw_after_timeout", {16'b0, state, mem_write, mem_timeout}, {16'b0, 4'd0, 1'b0, 1'b0});
        advance();

        // async reset in the middle of MEMREAD, then an unknown opcode
        do_reset();
        drive(1'b1, 1'b0, OP_LOAD, 3'd2); advance();
        drive(1'b0, 1'b0, OP_LOAD, 3'd2); advance();
        drive(1'b0, 1'b0, OP_LOAD, 3'd2); advance();
        drive(1'b0, 1'b0, OP_LOAD, 3'd2);
        check("lw_in_memread", {18'b0, state}, {18'b0, 4'd3});
        #2 rst = 1'b0;
        #1;
        check("async_reset_mid", {state, dut_vec[15:0]}, 20'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b1, 1'b0, 7'b0000000, 3'd0);
        check("illegal_fetch", {18'b0, state}, {18'b0, 4'd0});
        advance();
        drive(1'b0, 1'b0, 7'b0000000, 3'd0);
        check("illegal_decode", {18'b0, state}, {18'b0, 4'd1});
        advance();
        drive(1'b1, 1'b0, 7'b0000000, 3'd0);
`ifdef ILLEGAL_TRAP_EN
        check("illegal_trap", {state, dut_vec[15:0]}, {4'd11, 16'h0});
        advance();
        drive(1'b1, 1'b0, OP_RTYPE, 3'd0);
        check("trap_sticky", {state, dut_vec[15:0]}, {4'd11, 16'h0});
`else
        check("illegal_nop", {state, dut_vec[15:0]}, {4'd0, ref_out(0, 1'b1, 1'b0, 3'd0, 1'b0)});
`endif
        advance();

        // random instruction stream against the trace model
        do_reset();
        for (int n = 0; n < 300; n++) gen_instr();
        while (exp_q.size() > 0) begin
            logic [11:0] s;
            logic [21:0] e;
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            drive(s[0], s[1], s[11:5], s[4:2]);
            check("random", dut_vec, e);
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
